// File: rtl/timer_multi_if.sv
// Control and readback bundle between the timer register block (master)
// and the multi-channel timer core (slave).
interface timer_multi_if #(
    parameter int DATA_W  = 32,
    parameter int N_CH    = 4,
    parameter int PRESC_W = 16
);
    localparam int CNT_W = 2 * DATA_W;

    logic                    cke_i;
    logic [N_CH-1:0]         enable_i;
    logic [N_CH-1:0]         clear_i;
    logic [N_CH-1:0]         sample_i;
    logic [N_CH-1:0]         mode_i;
    logic [PRESC_W-1:0]      prescale_i;
    logic [N_CH*CNT_W-1:0]   compare_i;
    logic [N_CH-1:0]         irq_ack_i;
    logic [N_CH*CNT_W-1:0]   value_o;
    logic [N_CH-1:0]         irq_o;

    modport master (
        output cke_i, enable_i, clear_i, sample_i, mode_i,
        output prescale_i, compare_i, irq_ack_i,
        input  value_o, irq_o
    );

    modport slave (
        input  cke_i, enable_i, clear_i, sample_i, mode_i,
        input  prescale_i, compare_i, irq_ack_i,
        output value_o, irq_o
    );
endinterface

// File: rtl/timer_multi_core.sv
// N_CH independent 2*DATA_W-bit counters sharing one programmable prescaler.
// Each channel is free-running or periodic (compare/auto-reload) and raises
// a sticky interrupt on every period or wrap event. value_o holds snapshots
// taken on sample_i.
module timer_multi_core #(
    parameter int DATA_W  = 32,
    parameter int N_CH    = 4,
    parameter int PRESC_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    timer_multi_if.slave  bus
);
    localparam int CNT_W = 2 * DATA_W;

    logic [PRESC_W-1:0]          presc_q, presc_d;
    logic                        tick;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0][CNT_W-1:0]  value_q, value_d;
    logic [N_CH-1:0]             irq_q, irq_d;
    logic [N_CH-1:0]             evt;

    // Lowering prescale_i below the running count ticks at once (no wrap).
    assign tick = (presc_q >= bus.prescale_i);

    // Next-state for prescaler and channels; nothing moves while cke_i is low.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        irq_d   = irq_q;
        evt     = '0;
        if (bus.cke_i) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            for (int k = 0; k < N_CH; k++) begin
                // Clear has top priority and suppresses any event that cycle.
                if (bus.clear_i[k]) begin
                    cnt_d[k] = '0;
                end else if (tick && bus.enable_i[k]) begin
                    // Compare match and all-ones wrap coincide when C is all-ones:
                    // that is still a single event.
                    if ((bus.mode_i[k] && (cnt_q[k] == bus.compare_i[k*CNT_W +: CNT_W]))
                        || (&cnt_q[k])) begin
                        cnt_d[k] = '0;
                        evt[k]   = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                // Set beats acknowledge on the same edge.
                if (evt[k]) begin
                    irq_d[k] = 1'b1;
                end else if (bus.irq_ack_i[k]) begin
                    irq_d[k] = 1'b0;
                end
                // Snapshot captures the pre-edge count.
                if (bus.sample_i[k]) begin
                    value_d[k] = cnt_q[k];
                end
            end
        end
    end

    // State registers with synchronous reset that wins over cke_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            irq_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.value_o = value_q;
    assign bus.irq_o   = irq_q;

endmodule

// File: doc/timer_multi_core.md
# timer_multi_core

Multi-channel successor to the single 64-bit timer core. It provides N_CH independent counters of width 2*DATA_W that share one programmable prescaler. Each channel runs either free-running or in periodic compare/auto-reload mode, and raises a sticky interrupt on each period or overflow event. It sits behind the timer's software-register block: that block drives the control inputs and reads back the sampled values and interrupt flags.

## Interface
Parameters:
- DATA_W, default 32: register data width. Each channel counter is CNT_W = 2*DATA_W bits wide.
- N_CH, default 4: number of channels, 1..16.
- PRESC_W, default 16: width of the prescaler reload value.

Ports:
- clk_i  in  1  clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- cke_i  in  1  clock enable. While low, all state is frozen.
- enable_i  in  N_CH  per-channel count enable.
- clear_i  in  N_CH  per-channel counter clear, one-cycle pulse.
- sample_i  in  N_CH  per-channel snapshot strobe.
- mode_i  in  N_CH  per-channel mode: 0 = free-running, 1 = periodic compare.
- prescale_i  in  PRESC_W  shared prescaler reload value P.
- compare_i  in  N_CH*CNT_W  per-channel compare value C. Channel k occupies bits [k*CNT_W +: CNT_W].
- irq_ack_i  in  N_CH  per-channel interrupt acknowledge, one-cycle pulse.
- value_o  out  N_CH*CNT_W  per-channel sampled counter value, registered. Same packing as compare_i.
- irq_o  out  N_CH  per-channel sticky interrupt flag, registered.

## Operation
- **Reset.** On any edge with rst_i=1, regardless of cke_i, the following go to 0: prescaler counter, all channel counters, value_o, irq_o.
- **Clock enable.** With cke_i=0 and rst_i=0, no register changes. Strobes presented in that cycle (sample, clear, ack) are ignored.
- **Prescaler.**
  - presc_cnt (PRESC_W bits) increments every enabled cycle.
  - tick is combinational: tick = (presc_cnt >= prescale_i).
  - On an edge where tick=1, presc_cnt returns to 0.
  - P=0 gives tick every cycle. Lowering P below presc_cnt produces a tick on the next cycle, with no wrap-around.
  - The prescaler runs continuously and is independent of the channel enables.
- **Channel update**, evaluated per channel in priority order:
  1. clear_i=1: cnt <= 0. No event is generated, even if tick and enable_i are also high.
  2. tick & enable_i, mode_i=1, cnt == C: cnt <= 0 and a period event is generated.
  3. tick & enable_i, cnt == all-ones (either mode): cnt <= 0 and a wrap event is generated.
  4. tick & enable_i: cnt <= cnt + 1.
  5. Otherwise cnt holds.
- **Compare edge cases (mode 1).**
  - C=0 produces an event on every tick, and cnt stays 0.
  - If C is changed below the current cnt, the counter continues up to all-ones, wraps to 0 with an event, then matches the new C.
- **Interrupt flag.**
  - Any event sets irq_o[k].
  - irq_ack_i[k] clears it.
  - If an event and an ack occur on the same edge, set wins and irq_o stays 1.
  - The flag stays high until acknowledged. Multiple events before an ack collapse into one.
- **Sampling.**
  - sample_i[k]=1 loads value_o[k] with the pre-edge cnt value.
  - Sample in the same cycle as clear, increment or event captures the old value.
  - Otherwise value_o holds.
- **Channel independence.** Channels are fully independent. Only tick is shared.

## Timing
- **Sample latency.** value_o is valid 1 cycle after the sample_i edge and holds until the next sample or reset.
- **Count rate.** A channel enabled continuously increments once every P+1 enabled cycles.
- **Period (mode 1).** The event repeats every (C+1)*(P+1) enabled cycles. irq_o rises on the edge where cnt wraps to 0.
- **Free-running overflow.** Wrap occurs 2^CNT_W ticks after clear.
- **Clear latency.** cnt reads 0 on the cycle after clear_i. The first increment occurs at the next tick after that.
- **Clock-enable low.** Frozen cycles do not count toward prescaler or period cycle counts.
- **Reset mid-operation.** Reset aborts all counting. A pending irq is lost and the prescaler phase restarts at 0. The first tick after reset release with P=3 arrives on the 4th enabled cycle.

## Test plan
- Reset: drive rst_i=1 for 1 cycle during active counting on all channels -> value_o=0 and irq_o=0 the next cycle; counters restart from 0.
- Prescaler: N_CH=4, P=3, ch0 enabled free-running, sample after 40 cycles -> value_o[0]=10. Then set P=0 and run 5 more cycles -> value_o[0]=15 on the next sample.
- Periodic: ch1 mode=1, C=4, P=0 -> irq_o[1] rises exactly 5 cycles after enable. Ack it -> it rises again 5 cycles later. Event and ack on the same edge -> irq_o[1] stays 1.
- Wrap: preload by running DATA_W=4 (CNT_W=8), ch2 free-running, P=0 -> after 256 ticks cnt=0 and irq_o[2]=1. In mode 1 with C=0xFF -> a single event per 256 ticks, not two.
- Clear/sample priority: with cnt=7 on ch3, pulse clear_i, sample_i and tick together -> value_o[3]=7, cnt=0, no event. Hold cke_i=0 for 10 cycles -> cnt and irq unchanged.
- Independence: run ch0 (P-shared, C=2, mode 1) and ch1 (mode 0) while toggling enable_i[1] -> ch0 event spacing of 3*(P+1) cycles is unaffected.
